// File: rtl/sdram_init_refresh_pkg.sv
// Shared SDRAM definitions: command encodings, controller states, default timing.
// Also imported by the read/write controller and the command arbiter.
package sdram_init_refresh_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_LMR  = 4'b0000;
  localparam logic [3:0] CMD_INH  = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE, S_PWR, S_PRE, S_AREF, S_MRS, S_WAIT, S_READY, S_REF
  } state_e;

  typedef struct packed {
    logic        cke;
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic [1:0]  ba;
  } sdram_bus_t;

  localparam sdram_bus_t BUS_RST = '{cke: 1'b0, cmd: CMD_INH, addr: 13'd0, ba: 2'd0};

  localparam int          DEF_CLK_MHZ      = 100;
  localparam int          DEF_T_PWR_US     = 200;
  localparam int          DEF_T_RP         = 2;
  localparam int          DEF_T_RFC        = 7;
  localparam int          DEF_T_MRD        = 2;
  localparam int          DEF_INIT_REF_NUM = 8;
  localparam int          DEF_REF_INTERVAL = 781;
  localparam logic [12:0] DEF_MODE_REG     = 13'h0032;

  // Bits needed to hold 0..n-1.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// Refresh interval timer: raises ref_req every REF_INTERVAL cycles while enabled,
// flags ref_miss if an interval ends with the previous request still unserved.
module sdram_ref_timer
  import sdram_init_refresh_pkg::*;
#(
  parameter int REF_INTERVAL = DEF_REF_INTERVAL
) (
  input  logic clk_c1,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  input  logic ack,
  output logic ref_req,
  output logic ref_miss
);

  localparam int            TW   = cnt_w(REF_INTERVAL);
  localparam logic [TW-1:0] LAST = TW'(REF_INTERVAL - 1);

  logic [TW-1:0] tmr;
  logic          wrap;

  assign wrap = (tmr == LAST);

  always_ff @(posedge clk_c1 or negedge rst_n) begin
    if (!rst_n) begin
      tmr      <= '0;
      ref_req  <= 1'b0;
      ref_miss <= 1'b0;
    end else if (clear || !enable) begin
      tmr      <= '0;
      ref_req  <= 1'b0;
      ref_miss <= 1'b0;
    end else begin
      tmr     <= wrap ? '0 : tmr + 1'b1;
      // A wrap on the grant edge re-arms the request rather than losing it.
      ref_req <= wrap | (ref_req & ~ack);
      if (wrap && ref_req && !ack) ref_miss <= 1'b1;
    end
  end

endmodule

// File: rtl/sdram_init_refresh.sv
// SDRAM power-up init (power wait, PRECHARGE ALL, N x AUTO REFRESH, LOAD MODE)
// followed by periodic AUTO REFRESH under a request/grant handshake.
module sdram_init_refresh
  import sdram_init_refresh_pkg::*;
#(
  parameter int          CLK_MHZ      = DEF_CLK_MHZ,
  parameter int          T_PWR_US     = DEF_T_PWR_US,
  parameter int          T_RP         = DEF_T_RP,
  parameter int          T_RFC        = DEF_T_RFC,
  parameter int          T_MRD        = DEF_T_MRD,
  parameter int          INIT_REF_NUM = DEF_INIT_REF_NUM,
  parameter logic [12:0] MODE_REG     = DEF_MODE_REG,
  parameter int          REF_INTERVAL = DEF_REF_INTERVAL
) (
  input  logic        clk_c1,
  input  logic        rst_n,
  input  logic        sys_rst_n,
  input  logic        ref_grant,
  output logic        sdram_cke,
  output logic [3:0]  sdram_cmd,
  output logic [12:0] sdram_addr,
  output logic [1:0]  sdram_ba,
  output logic        bus_own,
  output logic        init_done,
  output logic        ref_req,
  output logic        ref_done,
  output logic        ref_miss
);

  localparam int            PWR_CYC  = CLK_MHZ * T_PWR_US;
  localparam int            PW       = cnt_w(PWR_CYC);
  localparam int            DW       = cnt_w(T_RFC) + 1;
  localparam int            SW       = cnt_w(INIT_REF_NUM + 2);
  localparam logic [PW-1:0] PWR_LAST = PW'(PWR_CYC - 1);
  // step_q counts init commands after PRECHARGE: 1..N refreshes, N+1 = mode set
  localparam logic [SW-1:0] STEP_LMR = SW'(INIT_REF_NUM);
  localparam logic [SW-1:0] STEP_RDY = SW'(INIT_REF_NUM + 1);

  state_e        state_q, state_d;
  logic [PW-1:0] pwr_q, pwr_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [SW-1:0] step_q, step_d;
  sdram_bus_t    bus_q, bus_d;
  logic          bus_own_d, init_done_d, ref_done_d;
  logic          grant_ok;

  assign grant_ok = (state_q == S_READY) && ref_req && ref_grant;

  always_ff @(posedge clk_c1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pwr_q   <= '0;
      dly_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      pwr_q   <= pwr_d;
      dly_q   <= dly_d;
      step_q  <= step_d;
    end
  end

  // Wait loads are T-2 because the issuing state itself takes one cycle.
  always_comb begin
    state_d = state_q;
    pwr_d   = pwr_q;
    dly_d   = dly_q;
    step_d  = step_q;
    if (!sys_rst_n) begin
      state_d = S_IDLE;
      pwr_d   = '0;
      dly_d   = '0;
      step_d  = '0;
    end else begin
      case (state_q)
        S_IDLE:  begin state_d = S_PWR; pwr_d = '0; end
        S_PWR:   if (pwr_q == PWR_LAST) state_d = S_PRE;
                 else pwr_d = pwr_q + 1'b1;
        S_PRE:   begin state_d = S_WAIT; dly_d = DW'(T_RP - 2); end
        S_AREF:  begin state_d = S_WAIT; dly_d = DW'(T_RFC - 2); end
        S_MRS:   begin state_d = S_WAIT; dly_d = DW'(T_MRD - 2); end
        S_WAIT: begin
          if (dly_q != '0) dly_d = dly_q - 1'b1;
          else if (step_q == STEP_RDY) state_d = S_READY;
          else begin
            state_d = (step_q == STEP_LMR) ? S_MRS : S_AREF;
            step_d  = step_q + 1'b1;
          end
        end
        S_READY: if (grant_ok) begin state_d = S_REF; dly_d = DW'(T_RFC - 1); end
        S_REF:   if (dly_q != '0) dly_d = dly_q - 1'b1;
                 else state_d = S_READY;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decode the next state so they register on the same edge as the state.
  always_comb begin
    bus_d       = '{cke: 1'b1, cmd: CMD_NOP, addr: 13'd0, ba: 2'd0};
    bus_own_d   = 1'b1;
    init_done_d = 1'b0;
    ref_done_d  = 1'b0;
    case (state_d)
      S_IDLE:  bus_d = BUS_RST;
      S_PRE:   begin bus_d.cmd = CMD_PRE; bus_d.addr[10] = 1'b1; end
      S_AREF:  bus_d.cmd = CMD_AREF;
      S_MRS:   begin bus_d.cmd = CMD_LMR; bus_d.addr = MODE_REG; end
      S_READY: begin
        bus_own_d   = 1'b0;
        init_done_d = 1'b1;
        ref_done_d  = (state_q == S_REF);
      end
      S_REF: begin
        init_done_d = 1'b1;
        if (state_q == S_READY) bus_d.cmd = CMD_AREF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_c1 or negedge rst_n) begin
    if (!rst_n) begin
      bus_q     <= BUS_RST;
      bus_own   <= 1'b1;
      init_done <= 1'b0;
      ref_done  <= 1'b0;
    end else begin
      bus_q     <= bus_d;
      bus_own   <= bus_own_d;
      init_done <= init_done_d;
      ref_done  <= ref_done_d;
    end
  end

  assign sdram_cke  = bus_q.cke;
  assign sdram_cmd  = bus_q.cmd;
  assign sdram_addr = bus_q.addr;
  assign sdram_ba   = bus_q.ba;

  sdram_ref_timer #(.REF_INTERVAL(REF_INTERVAL)) u_ref_timer (
    .clk_c1   (clk_c1),
    .rst_n    (rst_n),
    .enable   (init_done),
    .clear    (!sys_rst_n),
    .ack      (grant_ok),
    .ref_req  (ref_req),
    .ref_miss (ref_miss)
  );

endmodule

// File: tb/tb_sdram_init_refresh.sv
// Directed bench for sdram_init_refresh: init sequence timing, refresh handshake,
// missed-refresh flag, sys_rst_n drops and asynchronous reset.
module tb_sdram_init_refresh;

  logic        clk_c1 = 1'b0;
  logic        rst_n, sys_rst_n, ref_grant;
  logic        sdram_cke;
  logic [3:0]  sdram_cmd;
  logic [12:0] sdram_addr;
  logic [1:0]  sdram_ba;
  logic        bus_own, init_done, ref_req, ref_done, ref_miss;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int r0     = 0;

  localparam logic [3:0]  NOP  = 4'b0111;
  localparam logic [3:0]  PRE  = 4'b0010;
  localparam logic [3:0]  AREF = 4'b0001;
  localparam logic [3:0]  LMR  = 4'b0000;
  localparam logic [3:0]  INH  = 4'b1111;
  // {cke, cmd, addr, ba, bus_own, init_done, ref_req, ref_done, ref_miss}
  localparam logic [24:0] RST_OUTS = {1'b0, 4'b1111, 13'd0, 2'd0, 1'b1, 4'b0000};

  wire [24:0] outs = {sdram_cke, sdram_cmd, sdram_addr, sdram_ba,
                      bus_own, init_done, ref_req, ref_done, ref_miss};

  sdram_init_refresh dut (
    .clk_c1     (clk_c1),
    .rst_n      (rst_n),
    .sys_rst_n  (sys_rst_n),
    .ref_grant  (ref_grant),
    .sdram_cke  (sdram_cke),
    .sdram_cmd  (sdram_cmd),
    .sdram_addr (sdram_addr),
    .sdram_ba   (sdram_ba),
    .bus_own    (bus_own),
    .init_done  (init_done),
    .ref_req    (ref_req),
    .ref_done   (ref_done),
    .ref_miss   (ref_miss)
  );

  always #5 clk_c1 = ~clk_c1;

  task automatic step();
    @(posedge clk_c1);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sys_rst_n = 1'b0; ref_grant = 1'b0;
    #12;
    checks++;
    if (outs !== RST_OUTS) begin errors++; $display("FAIL reset_values got %h want %h", outs, RST_OUTS); end
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      checks++;
      if (sdram_cmd !== INH || sdram_cke !== 1'b0 || init_done !== 1'b0) begin
        errors++; $display("FAIL idle_hold cyc %0d cmd=%b cke=%b done=%b want 1111/0/0", i, sdram_cmd, sdram_cke, init_done);
      end
    end
  endtask

  task automatic test_init();
    int p;
    logic [3:0] exp;
    sys_rst_n = 1'b1;
    step();
    checks++;
    if (sdram_cke !== 1'b1 || sdram_cmd !== NOP) begin errors++; $display("FAIL init_cke_rise cke=%b cmd=%b want 1/0111", sdram_cke, sdram_cmd); end
    p = cyc + 20000;
    step_to(p - 1);
    checks++;
    if (sdram_cmd !== NOP || bus_own !== 1'b1) begin errors++; $display("FAIL pwr_wait_end cmd=%b own=%b want 0111/1", sdram_cmd, bus_own); end
    step();
    checks++;
    if (sdram_cmd !== PRE || sdram_addr[10] !== 1'b1) begin errors++; $display("FAIL init_pre cmd=%b a10=%b want 0010/1", sdram_cmd, sdram_addr[10]); end
    for (int d = 1; d <= 60; d++) begin
      step();
      exp = (d == 58) ? LMR : (d >= 2 && d <= 51 && (d - 2) % 7 == 0) ? AREF : NOP;
      checks++;
      if (sdram_cmd !== exp) begin errors++; $display("FAIL init_cmd PRE+%0d got %b want %b", d, sdram_cmd, exp); end
      checks++;
      if (init_done !== (d == 60) || bus_own !== (d != 60)) begin
        errors++; $display("FAIL init_flags PRE+%0d done=%b own=%b", d, init_done, bus_own);
      end
      if (d == 58) begin
        checks++;
        if (sdram_addr !== 13'h0032 || sdram_ba !== 2'd0) begin errors++; $display("FAIL init_mode addr=%h ba=%0d want 0032/0", sdram_addr, sdram_ba); end
      end
    end
  endtask

  task automatic test_refresh_grant_high();
    int r, w;
    r = cyc;
    ref_grant = 1'b1;
    for (int i = 0; i < 2; i++) begin
      w = r + 781 * (i + 1);
      step_to(w - 1);
      checks++;
      if (ref_req !== 1'b0) begin errors++; $display("FAIL ref_req_early int %0d got %b want 0", i, ref_req); end
      step();
      checks++;
      if (ref_req !== 1'b1 || sdram_cmd !== NOP) begin errors++; $display("FAIL ref_req_rise int %0d req=%b cmd=%b want 1/0111", i, ref_req, sdram_cmd); end
      step();
      checks++;
      if (sdram_cmd !== AREF || bus_own !== 1'b1 || ref_req !== 1'b0) begin
        errors++; $display("FAIL ref_aref int %0d cmd=%b own=%b req=%b want 0001/1/0", i, sdram_cmd, bus_own, ref_req);
      end
      for (int j = 1; j < 7; j++) begin
        step();
        checks++;
        if (sdram_cmd !== NOP || bus_own !== 1'b1 || ref_done !== 1'b0) begin
          errors++; $display("FAIL ref_window int %0d +%0d cmd=%b own=%b done=%b", i, j, sdram_cmd, bus_own, ref_done);
        end
      end
      step();
      checks++;
      if (ref_done !== 1'b1 || bus_own !== 1'b0) begin errors++; $display("FAIL ref_done int %0d done=%b own=%b want 1/0", i, ref_done, bus_own); end
      step();
      checks++;
      if (ref_done !== 1'b0 || ref_miss !== 1'b0) begin errors++; $display("FAIL ref_after int %0d done=%b miss=%b want 0/0", i, ref_done, ref_miss); end
    end
    ref_grant = 1'b0;
  endtask

  task automatic test_sys_rst_drop();
    int p;
    sys_rst_n = 1'b0;
    step();
    checks++;
    if (outs !== RST_OUTS) begin errors++; $display("FAIL drop_ready got %h want %h", outs, RST_OUTS); end
    repeat (3) step();
    sys_rst_n = 1'b1;
    step();
    checks++;
    if (sdram_cke !== 1'b1) begin errors++; $display("FAIL reraise_cke got %b want 1", sdram_cke); end
    p = cyc + 20000;
    step_to(p + 30);
    checks++;
    if (sdram_cmd !== AREF) begin errors++; $display("FAIL fifth_aref got %b want 0001", sdram_cmd); end
    step_to(p + 32);
    checks++;
    if (sdram_cmd !== NOP) begin errors++; $display("FAIL fifth_wait got %b want 0111", sdram_cmd); end
    sys_rst_n = 1'b0;
    step();
    checks++;
    if (outs !== RST_OUTS) begin errors++; $display("FAIL drop_init got %h want %h", outs, RST_OUTS); end
    step();
    checks++;
    if (outs !== RST_OUTS) begin errors++; $display("FAIL drop_hold got %h want %h", outs, RST_OUTS); end
  endtask

  task automatic test_refresh_miss();
    int n;
    r0 = cyc;
    ref_grant = 1'b0;
    step_to(r0 + 780);
    checks++;
    if (ref_req !== 1'b0) begin errors++; $display("FAIL miss_req_early got %b want 0", ref_req); end
    step();
    checks++;
    if (ref_req !== 1'b1 || ref_miss !== 1'b0) begin errors++; $display("FAIL miss_req_rise req=%b miss=%b want 1/0", ref_req, ref_miss); end
    step_to(r0 + 1561);
    checks++;
    if (ref_miss !== 1'b0 || sdram_cmd !== NOP) begin errors++; $display("FAIL miss_early miss=%b cmd=%b want 0/0111", ref_miss, sdram_cmd); end
    step();
    checks++;
    if (ref_miss !== 1'b1 || ref_req !== 1'b1) begin errors++; $display("FAIL miss_set miss=%b req=%b want 1/1", ref_miss, ref_req); end
    ref_grant = 1'b1;
    step();
    checks++;
    if (sdram_cmd !== AREF || ref_req !== 1'b0 || bus_own !== 1'b1) begin
      errors++; $display("FAIL miss_aref cmd=%b req=%b own=%b want 0001/0/1", sdram_cmd, ref_req, bus_own);
    end
    n = 0;
    repeat (15) begin
      step();
      if (sdram_cmd === AREF) n++;
    end
    checks++;
    if (n !== 0) begin errors++; $display("FAIL miss_single_aref extra=%0d want 0", n); end
    checks++;
    if (ref_miss !== 1'b1) begin errors++; $display("FAIL miss_sticky got %b want 1", ref_miss); end
  endtask

  task automatic test_async_reset();
    step_to(r0 + 2346);
    checks++;
    if (bus_own !== 1'b1 || sdram_cmd !== NOP || init_done !== 1'b1) begin
      errors++; $display("FAIL mid_refresh own=%b cmd=%b done=%b want 1/0111/1", bus_own, sdram_cmd, init_done);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== RST_OUTS) begin errors++; $display("FAIL async_reset got %h want %h", outs, RST_OUTS); end
    ref_grant = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_init();
    test_refresh_grant_high();
    test_sys_rst_drop();
    test_init();
    test_refresh_miss();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
